// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM state
// encoding, mux/ALU code constants and the packed control word.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle.
//   opcode, mem_ready        : datapath/memory -> controller
//   enables, selects, status : controller -> datapath
// master = controller side, slave = datapath side.
interface mc_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, bus_error
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, bus_error
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter.
//   CLK, RESET (async active-low)
//   i_clear   : zero the counter (state change)
//   i_waiting : memory state with mem_ready low this cycle
//   o_timeout : this waiting cycle is the (MAX_WAIT+1)th in a row
module mc_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clear,
  input  logic i_waiting,
  output logic o_timeout
);
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         r_cnt <= '0;
    else if (i_clear)   r_cnt <= '0;
    else if (i_waiting) r_cnt <= r_cnt + 1'b1;
  end

  assign o_timeout = i_waiting && (r_cnt == MAX_CNT);
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller.
//   CLK, RESET (async active-low)
//   bus : mc_if.master -- opcode/mem_ready in; enables, selects,
//         instr_done and sticky illegal_op/bus_error out
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4; waits on mem_ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | rs + imm for lw/sw
// MEM_READ  | data read at ALUOut; waits on mem_ready
// MEM_WB    | MDR -> rt
// MEM_WRITE | data write at ALUOut; waits on mem_ready
// R_EXEC    | rs op rt (funct)
// R_WB      | ALUOut -> rd
// BRANCH    | rs - rt, PC <= ALUOut if zero
// JUMP      | PC <= jump target
// ADDI_EXEC | rs + imm
// ADDI_WB   | ALUOut -> rt
// TRAP      | halted until reset
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic CLK,
  input  logic RESET,
  mc_if.master bus
);
  state_t r_state, w_next;
  ctrl_t  w_ctrl;
  logic   r_illegal_op, r_bus_error;
  logic   w_waiting, w_timeout, w_bad_op;

  assign w_waiting = ((r_state == FETCH) || (r_state == MEM_READ) ||
                      (r_state == MEM_WRITE)) && !bus.mem_ready;

  assign w_bad_op = !((bus.opcode == OP_R)   || (bus.opcode == OP_LW) ||
                      (bus.opcode == OP_SW)  || (bus.opcode == OP_BEQ) ||
                      (bus.opcode == OP_J)   || (bus.opcode == OP_ADDI));

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_clear   (w_next != r_state),
    .i_waiting (w_waiting),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= FETCH;
      r_illegal_op <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE && w_bad_op) r_illegal_op <= 1'b1;
      if (w_timeout)                     r_bus_error  <= 1'b1;
    end
  end

  // mem_ready beats the timeout when both occur in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: begin
        if (bus.mem_ready)  w_next = DECODE;
        else if (w_timeout) w_next = TRAP;
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = MEM_ADDR;
          OP_R:         w_next = R_EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDI_EXEC;
          default:      w_next = TRAP;
        endcase
      end
      MEM_ADDR:  w_next = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (bus.mem_ready)  w_next = MEM_WB;
        else if (w_timeout) w_next = TRAP;
      end
      MEM_WRITE: begin
        if (bus.mem_ready)  w_next = FETCH;
        else if (w_timeout) w_next = TRAP;
      end
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: w_next = FETCH;
      R_EXEC:    w_next = R_WB;
      ADDI_EXEC: w_next = ADDI_WB;
      TRAP:      w_next = TRAP;
      default:   w_next = TRAP;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = bus.mem_ready;
        w_ctrl.pc_write  = bus.mem_ready;
      end
      DECODE:    w_ctrl.alu_src_b = SRCB_IMM_SH2;
      MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.i_or_d     = 1'b1;
        w_ctrl.instr_done = bus.mem_ready;
      end
      R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.pc_source  = PCSRC_JUMP;
        w_ctrl.instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      ADDI_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
    // Reset kills every enable and select immediately, not at the next edge.
    if (!RESET) w_ctrl = '0;
  end

  assign bus.PCWrite     = w_ctrl.pc_write;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign bus.IorD        = w_ctrl.i_or_d;
  assign bus.MemRead     = w_ctrl.mem_read;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.IRWrite     = w_ctrl.ir_write;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.instr_done  = w_ctrl.instr_done;
  assign bus.illegal_op  = r_illegal_op;
  assign bus.bus_error   = r_bus_error;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are
// queued when inputs are driven and checked at the following falling edge.
module tb_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MREAD = 3, S_MWB = 4;
  localparam int S_MWRITE = 5, S_REXEC = 6, S_RWB = 7, S_BR = 8, S_JMP = 9;
  localparam int S_AEXEC = 10, S_AWB = 11, S_TRAP = 12, S_RST = 13;

  typedef struct {
    string       tag;
    logic [18:0] w;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  mc_if bus ();

  multicycle_control #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Expected word, bit order:
  // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] instr_done illegal_op bus_error
  function automatic logic [18:0] ew(input int st, input bit mr,
                                     input bit ill, input bit be);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, dn;
    logic [1:0] sb, op, ps;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, dn} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: sb = 2'b11;
      S_MADDR:  begin sa = 1; sb = 2'b10; end
      S_MREAD:  begin mrd = 1; iord = 1; end
      S_MWB:    begin rw = 1; m2r = 1; dn = 1; end
      S_MWRITE: begin mwr = 1; iord = 1; dn = mr; end
      S_REXEC:  begin sa = 1; op = 2'b10; end
      S_RWB:    begin rw = 1; rdst = 1; dn = 1; end
      S_BR:     begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; dn = 1; end
      S_JMP:    begin pcw = 1; ps = 2'b10; dn = 1; end
      S_AEXEC:  begin sa = 1; sb = 2'b10; end
      S_AWB:    begin rw = 1; dn = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, op, ps,
            dn, ill, be};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.instr_done,
            bus.illegal_op, bus.bus_error};
  endfunction

  task automatic push(input string tag, input logic [18:0] w);
    exp_t e;
    e.tag = tag;
    e.w   = w;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [18:0] o;
    n_run++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h expected=queued entry", obs());
      return;
    end
    e = sb_q.pop_front();
    o = obs();
    assert (o === e.w) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", e.tag, o, e.w);
    end
  endtask

  // Called at posedge+1: drive inputs for this cycle, check at the falling edge.
  task automatic cyc(input string tag, input bit mr, input logic [5:0] op,
                     input logic [18:0] w);
    bus.mem_ready = mr;
    bus.opcode    = op;
    push(tag, w);
    @(negedge CLK);
    pop_check();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_now(input string tag, input logic [18:0] w);
    push(tag, w);
    pop_check();
  endtask

  // From posedge+1: pulse reset mid-cycle and resync with FETCH held.
  task automatic do_reset(input string tag);
    #2 RESET = 1'b0;
    #1 chk_now(tag, ew(S_RST, 0, 0, 0));
    bus.mem_ready = 1'b0;
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    bus.opcode    = LW;
    #3 chk_now("reset_idle", ew(S_RST, 0, 0, 0));
    @(posedge CLK);
    #1 chk_now("reset_edge_mr1", ew(S_RST, 0, 0, 0));
    bus.mem_ready = 1'b0;
    #2 RESET = 1'b1;
    #1 chk_now("release_fetch", ew(S_FETCH, 0, 0, 0));
    @(posedge CLK);
    #1;

    // lw, zero wait: 5 cycles
    cyc("lw_fetch",  1, LW, ew(S_FETCH, 1, 0, 0));
    cyc("lw_decode", 1, LW, ew(S_DECODE, 1, 0, 0));
    cyc("lw_addr",   1, LW, ew(S_MADDR, 1, 0, 0));
    cyc("lw_read",   1, LW, ew(S_MREAD, 1, 0, 0));
    cyc("lw_wb",     1, LW, ew(S_MWB, 1, 0, 0));
    // R then beq back-to-back
    cyc("r_fetch",   1, RT, ew(S_FETCH, 1, 0, 0));
    cyc("r_decode",  1, RT, ew(S_DECODE, 1, 0, 0));
    cyc("r_exec",    1, RT, ew(S_REXEC, 1, 0, 0));
    cyc("r_wb",      1, RT, ew(S_RWB, 1, 0, 0));
    cyc("beq_fetch", 1, BEQ, ew(S_FETCH, 1, 0, 0));
    cyc("beq_decode",1, BEQ, ew(S_DECODE, 1, 0, 0));
    cyc("beq_branch",1, BEQ, ew(S_BR, 1, 0, 0));
    // addi and j
    cyc("addi_fetch", 1, ADDI, ew(S_FETCH, 1, 0, 0));
    cyc("addi_decode",1, ADDI, ew(S_DECODE, 1, 0, 0));
    cyc("addi_exec",  1, ADDI, ew(S_AEXEC, 1, 0, 0));
    cyc("addi_wb",    1, ADDI, ew(S_AWB, 1, 0, 0));
    cyc("j_fetch",    1, JMP, ew(S_FETCH, 1, 0, 0));
    cyc("j_decode",   1, JMP, ew(S_DECODE, 1, 0, 0));
    cyc("j_jump",     1, JMP, ew(S_JMP, 1, 0, 0));
    // fetch with 3 wait cycles
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 0, JMP, ew(S_FETCH, 0, 0, 0));
    cyc("fetch_ready",  1, JMP, ew(S_FETCH, 1, 0, 0));
    cyc("fetch_decode", 1, JMP, ew(S_DECODE, 1, 0, 0));
    cyc("fetch_jump",   1, JMP, ew(S_JMP, 1, 0, 0));
    // sw: ready arrives on the 16th waiting cycle, no error
    cyc("sw_fetch",  1, SW, ew(S_FETCH, 1, 0, 0));
    cyc("sw_decode", 1, SW, ew(S_DECODE, 1, 0, 0));
    cyc("sw_addr",   1, SW, ew(S_MADDR, 1, 0, 0));
    for (int i = 0; i < 15; i++) cyc("sw_wait", 0, SW, ew(S_MWRITE, 0, 0, 0));
    cyc("sw_ready16", 1, SW, ew(S_MWRITE, 1, 0, 0));
    cyc("sw_back_fetch", 0, SW, ew(S_FETCH, 0, 0, 0));
    // reset mid MEM_WRITE (fetch above holds one wait cycle, then resumes)
    cyc("sw2_fetch",  1, SW, ew(S_FETCH, 1, 0, 0));
    cyc("sw2_decode", 1, SW, ew(S_DECODE, 1, 0, 0));
    cyc("sw2_addr",   1, SW, ew(S_MADDR, 1, 0, 0));
    cyc("sw2_write",  0, SW, ew(S_MWRITE, 0, 0, 0));
    #2 RESET = 1'b0;
    #1;
    n_run++;
    assert (bus.MemWrite === 1'b0) else begin
      n_fail++;
      $error("FAIL rst_kill_memwrite observed=%b expected=0", bus.MemWrite);
    end
    chk_now("rst_kill_all", ew(S_RST, 0, 0, 0));
    #1 RESET = 1'b1;
    #1 chk_now("rst_release_fetch", ew(S_FETCH, 0, 0, 0));
    @(posedge CLK);
    #1 chk_now("rst_first_edge_fetch", ew(S_FETCH, 0, 0, 0));
    cyc("post_rst_fetch",  1, JMP, ew(S_FETCH, 1, 0, 0));
    cyc("post_rst_decode", 1, JMP, ew(S_DECODE, 1, 0, 0));
    cyc("post_rst_jump",   1, JMP, ew(S_JMP, 1, 0, 0));
    // illegal opcode
    cyc("ill_fetch",  1, BAD, ew(S_FETCH, 1, 0, 0));
    cyc("ill_decode", 1, BAD, ew(S_DECODE, 1, 0, 0));
    for (int i = 0; i < 11; i++)
      cyc("ill_trap", i[0], BAD, ew(S_TRAP, 0, 1, 0));
    do_reset("rst_after_ill");
    // sw timeout: 16 waiting cycles then TRAP with bus_error
    cyc("swto_fetch",  1, SW, ew(S_FETCH, 1, 0, 0));
    cyc("swto_decode", 1, SW, ew(S_DECODE, 1, 0, 0));
    cyc("swto_addr",   1, SW, ew(S_MADDR, 1, 0, 0));
    for (int i = 0; i < 16; i++) cyc("swto_wait", 0, SW, ew(S_MWRITE, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc("swto_trap", i[0], SW, ew(S_TRAP, 0, 0, 1));
    do_reset("rst_after_be");
    cyc("final_fetch", 0, SW, ew(S_FETCH, 0, 0, 0));

    n_run++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing controller for the multi-cycle MIPS datapath variant. It replaces the single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file, ALU-mux and memory enables. It handshakes with a shared instruction/data memory through mem_ready, and traps on illegal opcodes or memory timeouts.

Parameters:
MAX_WAIT, 15, maximum consecutive cycles a memory state waits for mem_ready before a bus error.
WAIT_W, 4, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
CLK  input  1  single clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
opcode  input  6  Instruction[31:26] taken from the IR.
mem_ready  input  1  memory has completed the current read/write this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load qualified externally by ALU zero.
IorD  output  1  memory address select: 0=PC, 1=ALUOut.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
IRWrite  output  1  instruction register load.
MemtoReg  output  1  register write data select: 0=ALUOut, 1=MDR.
RegDst  output  1  write register select: 0=rt, 1=rd.
RegWrite  output  1  register-file write enable.
ALUSrcA  output  1  ALU A select: 0=PC, 1=rs.
ALUSrcB  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded.
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
illegal_op  output  1  sticky; set on entering TRAP through an undefined opcode.
bus_error  output  1  sticky; set on entering TRAP through a memory timeout.

Behaviour:
- Reset: while RESET=0, state=FETCH, wait counter=0, illegal_op=0, bus_error=0. All enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done) are forced 0. All mux selects and ALUOp are 0.
- Reset assertion mid-operation kills any in-progress MemWrite/RegWrite combinationally in the same cycle. After release, the first clocked state is FETCH.
- Outputs are combinational from state, with one exception: in memory states, IRWrite and PCWrite are additionally qualified by mem_ready.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode: lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, any other->TRAP with illegal_op set.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for mem_ready, then go to FETCH. instr_done=mem_ready.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state FETCH.
- Cycle counts with zero wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Wait counter, applies in FETCH, MEM_READ and MEM_WRITE:
  - Cleared on entry to any state.
  - Increments on each cycle in which mem_ready=0.
  - If mem_ready=0 while the counter equals MAX_WAIT (i.e. the (MAX_WAIT+1)th waiting cycle), next state is TRAP and bus_error is set.
  - mem_ready=1 in the same cycle wins over the timeout.
- TRAP: all enables 0. The FSM stays in TRAP until reset; illegal_op and bus_error hold their values.
- State encoding is 4-bit binary with FETCH=0. Any unused encoding goes to TRAP.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants;
  - the state enum (FETCH..TRAP);
  - ALUOp, ALUSrcB and PCSource code constants.
- One sub-module, mc_wait_timer, contains the parameterised wait counter. Its inputs are clear, waiting and RESET; its output is a timeout flag.
- The FSM and the output decode stay in multicycle_control.

Test Plan:
- lw (opcode 100011), mem_ready held at 1: states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB over 5 cycles. RegWrite=1 and MemtoReg=1 only in cycle 5, instr_done pulses once.
- R-type then beq (000100) back-to-back: R takes 4 cycles with RegDst=1 in R_WB. beq takes 3 cycles with PCWriteCond=1, ALUOp=01, PCSource=01 in cycle 3.
- FETCH with mem_ready low for 3 cycles then high: MemRead=1 for 4 cycles. IRWrite and PCWrite are asserted only in cycle 4, and DECODE follows.
- opcode 111111 in DECODE: next state TRAP, illegal_op=1. No enables toggle for 10 further cycles, even with mem_ready toggling.
- sw with mem_ready stuck at 0 and MAX_WAIT=15: MemWrite=1 for 16 cycles, then TRAP with bus_error=1. With mem_ready=1 on the 16th cycle instead: return to FETCH and no error.
- RESET driven low mid-MEM_WRITE (asynchronous, between clock edges): MemWrite drops to 0 immediately. After release, FETCH is active on the first edge with MemRead=1.
